dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and retry controller in front of the data memory. It shares the single memory port between requester 0 (execution unit load/store) and requester 1 (loader/debug port). Every access is sequenced through a fixed three-state FSM. An access the memory refuses on its periodic refusal cycle is transparently re-issued, so requesters never see a refusal. It sits between the execution-unit datapath and the memory, and drives all memory request inputs.

## Interface
- A_WIDTH, 13, memory word-address width
- D_WIDTH, 34, data width
- CNT_WIDTH, 16, width of the refusal statistics counter
- clk  in  1  clock; all logic on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- p0_req_i / p1_req_i  in  1  access request; held high with fields stable until the matching ack
- p0_we_i / p1_we_i  in  1  1 = write, 0 = read
- p0_addr_i / p1_addr_i  in  A_WIDTH  word address
- p0_wdata_i / p1_wdata_i  in  D_WIDTH  write data
- p0_ack_o / p1_ack_o  out  1  one-cycle completion pulse
- rdata_o  out  D_WIDTH  read data; valid only in a read-ack cycle, otherwise all ones
- mem_req_o  out  1  to memory read/write request
- mem_we_o  out  1  to memory write enable
- mem_addr_o  out  A_WIDTH  to memory address
- mem_din_o  out  D_WIDTH  to memory write data
- mem_dout_i  in  D_WIDTH  from memory read data; valid the cycle after a request
- mem_refused_i  in  1  from memory; high the cycle after a refused request
- busy_o  out  1  high whenever state ≠ IDLE
- refuse_cnt_o  out  CNT_WIDTH  saturating count of refused accesses

## Operation
- States: IDLE, ACCESS, CHECK. Reset state is IDLE.
- IDLE:
  - If no request is pending, remain in IDLE.
  - Otherwise select a grant: if only one port requests, grant it; if both request, grant the port that was not granted last (round-robin). last_grant resets to 1, so port 0 wins the first tie.
  - Latch grant, we, addr and wdata into registers, update last_grant, then go to ACCESS.
- ACCESS:
  - mem_req_o=1; mem_we_o, mem_addr_o and mem_din_o are driven from the latched registers.
  - Unconditionally go to CHECK.
- CHECK:
  - mem_req_o=0. Sample mem_refused_i.
  - If mem_refused_i=1: no ack; refuse_cnt_o increments, saturating at all ones; return to ACCESS with the same latched request. The memory suppresses refused writes internally, so re-issue is always safe.
  - If mem_refused_i=0: assert ack_o of the granted port combinationally. For a read, rdata_o = mem_dout_i. Go to IDLE.
- Outside ACCESS, mem_we_o=0 and mem_req_o=0. mem_addr_o and mem_din_o hold their latched values.
- rdata_o is all ones except in a non-refused read CHECK cycle. A write ack also shows all ones.
- Requests are never dropped. A requester that deasserts req_i before its ack has been granted is simply not served. A requester that deasserts after grant still completes, and the ack pulse is still issued.
- At most one ack is high in any cycle.

## Timing
- Unrefused access: request sampled in IDLE at cycle t, mem_req_o high in t+1, ack in t+2, IDLE again in t+3. Minimum latency is 2 cycles from sample to ack; back-to-back throughput is one access per 3 cycles.
- Each refusal adds exactly 2 cycles (CHECK→ACCESS→CHECK).
- Requesters observe the ack at the clock edge that ends CHECK. They may drop or change req in the following IDLE cycle, which is the cycle the arbiter samples. The same request is therefore never served twice.
- Reset values: state IDLE, last_grant 1, both acks 0, rdata_o all ones, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_din_o 0, busy_o 0, refuse_cnt_o 0.
- Reset mid-access:
  - Takes effect at the next edge. The access is abandoned with no ack, and mem_req_o is 0 in the following cycle.
  - A write already presented in ACCESS may have committed. Requesters must re-issue after reset.
- Simultaneous new request and completion: a request that arrives during CHECK waits for IDLE. There is no bypass.
- refuse_cnt_o wraps never; it holds at 2^CNT_WIDTH−1.

## Test plan
- Single read: memory model holds 0x2_0000_0ABC at address 0x010, no refusal; p0 reads 0x010. Required: p0_ack_o high 2 cycles after sample, rdata_o=0x2_0000_0ABC, p1_ack_o stays 0.
- Write then read: p1 writes 0x1_2345_6789 to 0x1FFF, then p1 reads 0x1FFF. Required: the write ack shows rdata_o all ones; the read returns 0x1_2345_6789.
- Refusal retry: model asserts mem_refused_i on the first CHECK of a p0 write to 0x005. Required:
  - mem_req_o re-asserts 2 cycles later.
  - p0_ack_o arrives 4 cycles after sample.
  - refuse_cnt_o=1.
  - A later read of 0x005 returns the written data.
- Contention: p0 and p1 both request continuously for 4 accesses. Required: grants alternate p0, p1, p0, p1; acks occur every 3 cycles.
- Reset mid-operation: drop reset_n_i during ACCESS of a p1 read. Required: no ack, and in the next cycle state IDLE, busy_o=0, mem_req_o=0, refuse_cnt_o=0.
- Counter saturation with CNT_WIDTH=2: force 5 refusals. Required: refuse_cnt_o holds at 3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter with transparent retry of refused data-memory accesses
// Ports: p0_*/p1_* requester channels (req/we/addr/wdata in, ack out), rdata_o shared read data,
// mem_* memory request channel, busy_o while an access is in flight, refuse_cnt_o saturating refusal count.
module dmem_arbiter #(
   parameter int A_WIDTH   = 13,
   parameter int D_WIDTH   = 34,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n_i,
   input  logic                 p0_req_i,
   input  logic                 p0_we_i,
   input  logic [A_WIDTH-1:0]   p0_addr_i,
   input  logic [D_WIDTH-1:0]   p0_wdata_i,
   input  logic                 p1_req_i,
   input  logic                 p1_we_i,
   input  logic [A_WIDTH-1:0]   p1_addr_i,
   input  logic [D_WIDTH-1:0]   p1_wdata_i,
   output logic                 p0_ack_o,
   output logic                 p1_ack_o,
   output logic [D_WIDTH-1:0]   rdata_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [A_WIDTH-1:0]   mem_addr_o,
   output logic [D_WIDTH-1:0]   mem_din_o,
   input  logic [D_WIDTH-1:0]   mem_dout_i,
   input  logic                 mem_refused_i,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] refuse_cnt_o
);
   typedef enum logic [1:0] {IDLE, ACCESS, CHECK} state_t;
   state_t               state_q, state_d;
   logic                 last_q, last_d, gnt_q, gnt_d, we_q, we_d, done;
   logic [A_WIDTH-1:0]   addr_q, addr_d;
   logic [D_WIDTH-1:0]   wdata_q, wdata_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      case (state_q)
         IDLE: if (p0_req_i | p1_req_i) begin
            // on a tie the port not served last wins
            gnt_d   = (p0_req_i & p1_req_i) ? ~last_q : p1_req_i;
            last_d  = gnt_d;
            we_d    = gnt_d ? p1_we_i : p0_we_i;
            addr_d  = gnt_d ? p1_addr_i : p0_addr_i;
            wdata_d = gnt_d ? p1_wdata_i : p0_wdata_i;
            state_d = ACCESS;
         end
         ACCESS: state_d = CHECK;
         CHECK: if (mem_refused_i) begin
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            state_d = ACCESS;
         end else begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end
   assign mem_req_o    = state_q == ACCESS;
   assign mem_we_o     = mem_req_o & we_q;
   assign mem_addr_o   = addr_q;
   assign mem_din_o    = wdata_q;
   assign p0_ack_o     = done & ~gnt_q;
   assign p1_ack_o     = done & gnt_q;
   assign rdata_o      = (done & ~we_q) ? mem_dout_i : '1;
   assign busy_o       = state_q != IDLE;
   assign refuse_cnt_o = cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural refusing memory
module tb_dmem_arbiter;
   localparam int AW = 13;
   localparam int DW = 34;
   localparam logic [DW-1:0] ONES = '1;
   logic          clk = 1'b0;
   logic          reset_n_i = 1'b0;
   logic          p0_req_i = 1'b0, p0_we_i = 1'b0, p1_req_i = 1'b0, p1_we_i = 1'b0;
   logic [AW-1:0] p0_addr_i = '0, p1_addr_i = '0;
   logic [DW-1:0] p0_wdata_i = '0, p1_wdata_i = '0;
   logic          p0_ack_o, p1_ack_o, mem_req_o, mem_we_o, busy_o;
   logic [DW-1:0] rdata_o, mem_din_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_dout_i = '0;
   logic          mem_refused_i = 1'b0;
   logic [15:0]   refuse_cnt_o;
   logic          s_p0_ack, s_p1_ack, s_req, s_we, s_busy;
   logic [DW-1:0] s_rdata, s_din;
   logic [AW-1:0] s_addr;
   logic [1:0]    s_cnt;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            refuse_left = 0;
   int            cyc = 0;
   int            vectors = 0;
   int            miscompares = 0;
   typedef struct { logic port; logic [DW-1:0] rdata; int at; } exp_t;
   exp_t          exp_q[$];

   dmem_arbiter dut (
      .clk(clk), .reset_n_i(reset_n_i),
      .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
      .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
      .p0_ack_o(p0_ack_o), .p1_ack_o(p1_ack_o), .rdata_o(rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
      .mem_dout_i(mem_dout_i), .mem_refused_i(mem_refused_i),
      .busy_o(busy_o), .refuse_cnt_o(refuse_cnt_o));

   dmem_arbiter #(.CNT_WIDTH(2)) u_sat (
      .clk(clk), .reset_n_i(reset_n_i),
      .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
      .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
      .p0_ack_o(s_p0_ack), .p1_ack_o(s_p1_ack), .rdata_o(s_rdata),
      .mem_req_o(s_req), .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_din_o(s_din),
      .mem_dout_i(mem_dout_i), .mem_refused_i(mem_refused_i),
      .busy_o(s_busy), .refuse_cnt_o(s_cnt));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // memory: read data and refusal flag appear the cycle after a request; refused writes are dropped
   always @(posedge clk) begin
      mem_refused_i <= 1'b0;
      if (mem_req_o) begin
         if (refuse_left > 0) begin
            refuse_left = refuse_left - 1;
            mem_refused_i <= 1'b1;
         end else begin
            if (mem_we_o) mem[mem_addr_o] <= mem_din_o;
            mem_dout_i <= mem[mem_addr_o];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n_i && (p0_ack_o || p1_ack_o)) begin
         check("single_ack", 64'(p0_ack_o & p1_ack_o), 64'd0);
         if (exp_q.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ack_port", 64'(p1_ack_o), 64'(e.port));
            check("ack_rdata", 64'(rdata_o), 64'(e.rdata));
            check("ack_cycle", 64'(cyc), 64'(e.at));
         end
      end
   end

   task automatic issue(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input int nref, input logic push);
      exp_t e;
      @(negedge clk);
      if (port) begin
         p1_req_i = 1'b1; p1_we_i = we; p1_addr_i = addr; p1_wdata_i = wdata;
      end else begin
         p0_req_i = 1'b1; p0_we_i = we; p0_addr_i = addr; p0_wdata_i = wdata;
      end
      e.port = port; e.rdata = exp_rdata; e.at = cyc + 2 + 2 * nref;
      if (push) exp_q.push_back(e);
   endtask

   task automatic finish_port(input logic port);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = port ? p1_ack_o : p0_ack_o;
      end
      if (!got) check("ack_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      if (port) p1_req_i = 1'b0; else p0_req_i = 1'b0;
   endtask

   initial begin
      int t;
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[13'h010] = 34'h2_0000_0ABC;
      repeat (3) @(negedge clk);
      check("rst_p0_ack", 64'(p0_ack_o), 64'd0);
      check("rst_p1_ack", 64'(p1_ack_o), 64'd0);
      check("rst_rdata", 64'(rdata_o), 64'(ONES));
      check("rst_mem_req", 64'(mem_req_o), 64'd0);
      check("rst_mem_we", 64'(mem_we_o), 64'd0);
      check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
      check("rst_mem_din", 64'(mem_din_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_cnt", 64'(refuse_cnt_o), 64'd0);
      reset_n_i = 1'b1;
      // single read by p0
      issue(1'b0, 1'b0, 13'h010, '0, 34'h2_0000_0ABC, 0, 1'b1);
      finish_port(1'b0);
      // p1 write then read back, top address
      issue(1'b1, 1'b1, 13'h1FFF, 34'h1_2345_6789, ONES, 0, 1'b1);
      finish_port(1'b1);
      issue(1'b1, 1'b0, 13'h1FFF, '0, 34'h1_2345_6789, 0, 1'b1);
      finish_port(1'b1);
      // contention: p1 was served last, so p0 wins first and grants alternate
      @(negedge clk);
      t = cyc;
      p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 13'h010;
      p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 13'h1FFF;
      exp_q.push_back('{1'b0, 34'h2_0000_0ABC, t + 2});
      exp_q.push_back('{1'b1, 34'h1_2345_6789, t + 5});
      exp_q.push_back('{1'b0, 34'h2_0000_0ABC, t + 8});
      exp_q.push_back('{1'b1, 34'h1_2345_6789, t + 11});
      repeat (11) @(negedge clk);
      @(posedge clk);
      #1;
      p0_req_i = 1'b0; p1_req_i = 1'b0;
      // p0 write refused once, then retried
      refuse_left = 1;
      issue(1'b0, 1'b1, 13'h005, 34'h3_CAFE_0005, ONES, 1, 1'b1);
      @(negedge clk);
      check("retry_req1", 64'(mem_req_o), 64'd1);
      check("retry_we1", 64'(mem_we_o), 64'd1);
      check("retry_addr", 64'(mem_addr_o), 64'h005);
      @(negedge clk);
      check("retry_gap", 64'(mem_req_o), 64'd0);
      check("retry_busy", 64'(busy_o), 64'd1);
      @(negedge clk);
      check("retry_req2", 64'(mem_req_o), 64'd1);
      finish_port(1'b0);
      check("retry_cnt", 64'(refuse_cnt_o), 64'd1);
      issue(1'b0, 1'b0, 13'h005, '0, 34'h3_CAFE_0005, 0, 1'b1);
      finish_port(1'b0);
      // five refusals: the 2-bit counter saturates, the 16-bit one keeps counting
      refuse_left = 5;
      issue(1'b0, 1'b0, 13'h010, '0, 34'h2_0000_0ABC, 5, 1'b1);
      finish_port(1'b0);
      check("sat_cnt2", 64'(s_cnt), 64'd3);
      check("sat_cnt16", 64'(refuse_cnt_o), 64'd6);
      // reset during ACCESS of a p1 read abandons it silently
      issue(1'b1, 1'b0, 13'h1FFF, '0, '0, 0, 1'b0);
      @(negedge clk);
      check("mid_busy", 64'(busy_o), 64'd1);
      check("mid_req", 64'(mem_req_o), 64'd1);
      reset_n_i = 1'b0;
      p1_req_i = 1'b0;
      @(negedge clk);
      check("rstmid_busy", 64'(busy_o), 64'd0);
      check("rstmid_req", 64'(mem_req_o), 64'd0);
      check("rstmid_cnt", 64'(refuse_cnt_o), 64'd0);
      check("rstmid_ack", 64'(p1_ack_o | p0_ack_o), 64'd0);
      reset_n_i = 1'b1;
      repeat (4) @(negedge clk);
      check("rstmid_noack", 64'(p1_ack_o | p0_ack_o), 64'd0);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
